// File: rtl/bcd_seg_scanner.sv
// Two-digit BCD capture and common-anode seven-segment scanner with registered outputs.
// Optional leading-zero blanking of the tens digit is enabled by defining LZ_BLANK_EN.
module bcd_seg_scanner #(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Digit0,
    input  logic [3:0] Digit1,
    input  logic       Load,
    output logic       Ack,
    output logic [6:0] Seg,
    output logic [1:0] An
);

    localparam int unsigned    CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [7:0]      shadow_q, shadow_d;
    logic            ack_q, ack_d;
    logic [1:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      digit;
    logic [6:0]      pattern;

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        ack_d    = Load;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            sel_d = ~sel_q;
        end
        if (Load) begin
            shadow_d = {Digit1, Digit0};
        end
    end

    // Outputs are built from the pre-edge sel/shadow, giving one cycle of latency.
    always_comb begin
        digit = sel_q ? shadow_q[7:4] : shadow_q[3:0];
        an_d  = sel_q ? 2'b01 : 2'b10;
        case (digit)
            4'd0:    pattern = 7'h7E;
            4'd1:    pattern = 7'h30;
            4'd2:    pattern = 7'h6D;
            4'd3:    pattern = 7'h79;
            4'd4:    pattern = 7'h33;
            4'd5:    pattern = 7'h5B;
            4'd6:    pattern = 7'h5F;
            4'd7:    pattern = 7'h70;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h7B;
            default: pattern = 7'h01;
        endcase
        seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
`ifdef LZ_BLANK_EN
        if (sel_q && (shadow_q[7:4] == 4'h0)) begin
            an_d  = 2'b11;
            seg_d = SegOff;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            shadow_q <= 8'h00;
            ack_q    <= 1'b0;
            an_q     <= 2'b11;
            seg_q    <= SegOff;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            ack_q    <= ack_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign Ack = ack_q;
    assign Seg = seg_q;
    assign An  = an_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against An/Seg/Ack.
module tb_bcd_seg_scanner;

    localparam int unsigned Div = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d0, d1;
    logic       load;
    logic       ack;
    logic [6:0] seg;
    logic [1:0] an;

    bcd_seg_scanner #(
        .REFRESH_DIV   (Div),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .Digit0(d0),
        .Digit1(d1),
        .Load  (load),
        .Ack   (ack),
        .Seg   (seg),
        .An    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       ack;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    // Bench-side scan state used to decide which slot should be lit.
    int         m_cnt    = 0;
    logic       m_sel    = 1'b0;
    logic [7:0] m_shadow = 8'h00;

    // Hand-computed active-low segment codes (a..g on bit6..bit0).
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h01;
            4'd1:    return 7'h4F;
            4'd2:    return 7'h12;
            4'd3:    return 7'h06;
            4'd4:    return 7'h4C;
            4'd5:    return 7'h24;
            4'd6:    return 7'h20;
            4'd7:    return 7'h0F;
            4'd8:    return 7'h00;
            4'd9:    return 7'h04;
            default: return 7'h7E;
        endcase
    endfunction

    task automatic step(input logic r, input logic l, input logic [3:0] t, input logic [3:0] u);
        exp_t e;
        rst  = r;
        load = l;
        d1   = t;
        d0   = u;
        step_id++;
        e.id = step_id;
        if (r) begin
            e.an  = 2'b11;
            e.seg = 7'h7F;
            e.ack = 1'b0;
            m_cnt    = 0;
            m_sel    = 1'b0;
            m_shadow = 8'h00;
        end else begin
            e.ack = l;
            if (!m_sel) begin
                e.an  = 2'b10;
                e.seg = seg_code(m_shadow[3:0]);
            end else begin
                e.an  = 2'b01;
                e.seg = seg_code(m_shadow[7:4]);
`ifdef LZ_BLANK_EN
                if (m_shadow[7:4] == 4'h0) begin
                    e.an  = 2'b11;
                    e.seg = 7'h7F;
                end
`endif
            end
            if (m_cnt == Div - 1) begin
                m_cnt = 0;
                m_sel = ~m_sel;
            end else begin
                m_cnt++;
            end
            if (l) m_shadow = {t, u};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (an !== e.an) begin
                    n_fail++;
                    $display("FAIL an step%0d: got %b expected %b", e.id, an, e.an);
                end
                n_checks++;
                if (seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL seg step%0d: got %h expected %h", e.id, seg, e.seg);
                end
                n_checks++;
                if (ack !== e.ack) begin
                    n_fail++;
                    $display("FAIL ack step%0d: got %b expected %b", e.id, ack, e.ack);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst  = 1'b1;
        load = 1'b0;
        d0   = 4'h0;
        d1   = 4'h0;
        // 1: reset dominates Load
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h9, 4'h9);
        // shadow still 0: first edge shows units "0"
        idle(1);
        // 2: 05, single Ack pulse, observe both slots
        step(1'b0, 1'b1, 4'h0, 4'h5);
        idle(9);
        // 3: 12 over more than one full scan period
        step(1'b0, 1'b1, 4'h1, 4'h2);
        idle(17);
        // 4: invalid codes show dashes, tens not blanked
        step(1'b0, 1'b1, 4'hF, 4'hC);
        idle(9);
        // 5: Load coincident with the sel toggle
        while (m_cnt != Div - 1) idle(1);
        step(1'b0, 1'b1, 4'h7, 4'h3);
        idle(6);
        // Load held high: Ack stays set, recapture every cycle
        step(1'b0, 1'b1, 4'h4, 4'h8);
        step(1'b0, 1'b1, 4'h6, 4'h9);
        step(1'b0, 1'b1, 4'h0, 4'h1);
        idle(8);
        // 6: reset mid-scan with Load high, then restart showing "0"
        idle(2);
        step(1'b1, 1'b1, 4'h3, 4'h3);
        idle(10);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
Downstream display stage for the GCD datapath. It captures the two BCD result digits (Digit1 = tens, Digit0 = units) on a load strobe and time-multiplexes them onto a 2-digit common-anode seven-segment display. It has a refresh counter, a scan select and a shadow register with a capture acknowledge. Invalid BCD codes show a dash.

Parameters:
REFRESH_DIV, 4, clock cycles each digit stays lit (legal range >= 1)
SEG_ACTIVE_LOW, 1, 1 = Seg driven inverted (segment lit = 0); 0 = lit = 1

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Digit0  input  4  BCD units digit from GCD core
Digit1  input  4  BCD tens digit from GCD core
Load  input  1  capture strobe; samples Digit1/Digit0 into shadow
Ack  output  1  one-cycle pulse confirming capture
Seg  output  7  segment bus, bit6..bit0 = a,b,c,d,e,f,g
An  output  2  digit enables, active-low; An[0] = units, An[1] = tens

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-high. All state updates on the CLK rising edge.
- Reset values (at any edge with Reset=1):
  - cnt=0, sel=0, shadow=8'h00, Ack=0
  - An=2'b11 (all off)
  - Seg=all segments off: 7'h7F if SEG_ACTIVE_LOW, else 7'h00
- Reset dominates Load and the scan. Reset mid-scan returns everything to the reset values at that edge.
- Refresh counter:
  - cnt has width $clog2(REFRESH_DIV), minimum 1 bit.
  - Each cycle: if cnt==REFRESH_DIV-1, then cnt<=0 and sel<=~sel; otherwise cnt<=cnt+1.
  - REFRESH_DIV=1: sel toggles every cycle.
  - Full scan period = 2*REFRESH_DIV cycles.
- Capture:
  - Load=1 at an edge: shadow<={Digit1,Digit0} and Ack<=1. Otherwise Ack<=0.
  - Load held high: recapture every cycle; Ack stays 1.
  - No stall is applied to the source.
- Output register (1-cycle latency):
  - At each edge, An and Seg are loaded from the pre-edge sel and shadow.
  - A Load and a sel toggle at the same edge: outputs use the old shadow and old sel at that edge; the new values appear at the next edge.
- Digit select:
  - sel=0: An=2'b10, value = shadow[3:0]
  - sel=1: An=2'b01, value = shadow[7:4]
- Decode (logical pattern, lit=1, a..g):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - 10..15 = 01 (dash, g only)
  - Seg = SEG_ACTIVE_LOW ? ~pattern : pattern
- The first edge after Reset deasserts produces An=2'b10 with the decode of shadow[3:0].

Optional Feature:
Macro LZ_BLANK_EN.
- Defined: leading-zero blanking. When sel=1 and shadow[7:4]==0, An=2'b11 and Seg=all off for that slot. The units digit is never blanked, so a value of 0 still shows "0".
- Undefined: the tens digit is always driven, including a literal 0.

Test Plan (REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
1. Hold Reset=1 for 3 cycles with Load=1 and Digit1/Digit0=4'h9 -> An=2'b11, Seg=7'h7F, Ack=0, shadow stays 0.
2. Release Reset, pulse Load with Digit1=0, Digit0=5 (GCD of 10,5) -> Ack=1 for exactly one cycle. Units slot: An=2'b10, Seg=7'h24. Tens slot: with LZ_BLANK_EN, An=2'b11 and Seg=7'h7F; without it, An=2'b01 and Seg=7'h01.
3. Load Digit1=1, Digit0=2 -> An alternates 2'b10/2'b01 every 4 cycles, Seg=7'h12/7'h4F; the pattern repeats every 8 cycles.
4. Load Digit0=4'hC, Digit1=4'hF -> both slots show Seg=7'h7E (dash); the tens slot is not blanked.
5. Assert Load on the same edge where cnt==3 -> the first output after the toggle still shows the old shadow; the new value appears one edge later.
6. Assert Reset for 1 cycle mid-scan while Load=1 -> next cycle An=2'b11, Seg=7'h7F, Ack=0, cnt=0. The scan then restarts with the units slot showing "0".
